// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store access sequencer: size codes,
// sequencer states and the size-to-byte-count helper.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  // Number of bytes moved by an access of the given size code.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_merge_extend.sv
// Combines the one or two memory words of a load, aligns the addressed
// bytes to bit 0 and sign- or zero-extends them to 32 bits.
module load_merge_extend
  import lsu_pkg::*;
(
  input  logic [31:0] i_lo_word,
  input  logic [31:0] i_hi_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_result
);

  logic [5:0]  w_lo_shamt;
  logic [5:0]  w_hi_shamt;
  logic [31:0] w_aligned;

  // Low 32 bits of {hi,lo} >> 8*offset; a shift by 32 yields 0 for offset 0.
  always_comb begin
    w_lo_shamt = {1'b0, i_offset, 3'b000};
    w_hi_shamt = 6'd32 - w_lo_shamt;
    w_aligned  = (i_lo_word >> w_lo_shamt) | (i_hi_word << w_hi_shamt);
  end

  // Keep the low n bytes and extend from the top kept bit unless unsigned.
  always_comb begin
    o_result = w_aligned;
    case (i_size)
      SZ_B:    o_result = {{24{~i_unsigned & w_aligned[7]}}, w_aligned[7:0]};
      SZ_H:    o_result = {{16{~i_unsigned & w_aligned[15]}}, w_aligned[15:0]};
      default: o_result = w_aligned;
    endcase
  end

endmodule

// File: rtl/lsu_access_sequencer.sv
// Load/store access sequencer: turns one byte/half/word request into one or
// two aligned word transactions and returns a single extended response.
module lsu_access_sequencer
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  r_state;
  lsu_state_t  w_next;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_beat0;
  logic [31:0] r_rdata;

  logic [2:0]  w_nbytes;
  logic        w_split;
  logic        w_illegal;
  logic [7:0]  w_mask8;
  logic [63:0] w_data64;
  logic [31:0] w_base;
  logic [31:0] w_lo_word;
  logic [31:0] w_hi_word;
  logic [31:0] w_load_result;

  // Access geometry and store lane formation from the captured request.
  always_comb begin
    w_nbytes  = size_bytes(r_size);
    w_split   = ({2'b00, r_addr[1:0]} + {1'b0, w_nbytes}) > 4'd4;
    w_illegal = (r_size == 2'b11);
    w_mask8   = ((8'd1 << w_nbytes) - 8'd1) << r_addr[1:0];
    w_data64  = {32'h0, r_wdata} << {r_addr[1:0], 3'b000};
    w_base    = {r_addr[31:2], 2'b00};
  end

  // The first word comes straight from memory on an unsplit load and from
  // the saved beat on a split one; the second word only exists when split.
  always_comb begin
    w_lo_word = (r_state == ST_BEAT1) ? r_beat0 : mem_rdata;
    w_hi_word = (r_state == ST_BEAT1) ? mem_rdata : 32'h0;
  end

  load_merge_extend u_merge (
    .i_lo_word  (w_lo_word),
    .i_hi_word  (w_hi_word),
    .i_offset   (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_result   (w_load_result)
  );

  // Next-state and Moore outputs; memory outputs depend only on registers so
  // they stay stable for the whole of a wait-stated beat.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_be    = 4'h0;
    mem_wdata = 32'h0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = (req_size == 2'b11) ? ST_RESP : ST_BEAT0;
      end
      ST_BEAT0: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = w_base;
        mem_be    = r_we ? w_mask8[3:0] : 4'hF;
        mem_wdata = r_we ? w_data64[31:0] : 32'h0;
        if (mem_ack) w_next = w_split ? ST_BEAT1 : ST_RESP;
      end
      ST_BEAT1: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = w_base + 32'd4;
        mem_be    = r_we ? w_mask8[7:4] : 4'hF;
        mem_wdata = r_we ? w_data64[63:32] : 32'h0;
        if (mem_ack) w_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = w_illegal;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Capture the request fields on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
    end else if (req_valid && r_state == ST_IDLE) begin
      r_we       <= req_we;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
    end
  end

  // Save the first word so a split load can merge it with the second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_beat0 <= 32'h0;
    else if (r_state == ST_BEAT0 && mem_ack)   r_beat0 <= mem_rdata;
  end

  // Register the response data on entry to RESP; stores and errors return 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'h0;
    end else if (w_next == ST_RESP && r_state != ST_RESP) begin
      if (r_state == ST_IDLE || r_we) r_rdata <= 32'h0;
      else                            r_rdata <= w_load_result;
    end
  end

  assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_lsu_access_sequencer.sv
// Self-checking bench for lsu_access_sequencer: a wait-state capable word
// memory drives the DUT while a byte-addressed reference model predicts
// every response.
module tb_lsu_access_sequencer;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_unsigned;
  logic        req_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        memAck;
  logic [31:0] memRdata;

  lsu_access_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(memAck), .mem_rdata(memRdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } memTxn_t;

  memTxn_t     ackLog[$];
  logic [31:0] wordMem [logic [31:0]];
  logic [7:0]  refMem  [logic [31:0]];
  int waitCfg0 = 0, waitCfg1 = 0, waitCnt = 0, beatIdx = 0;
  int checks = 0, passes = 0, fails = 0;
  int obsLat, obsBeats, obsUnstable, obsReqCycles, logStart;
  logic [31:0] obsRdata, heldRdata;
  logic        obsErr;

  // Word memory responder: acks after the configured wait count per beat,
  // returns read data in the ack cycle and applies byte-enabled writes.
  always @(negedge clk) begin
    memAck   = 1'b0;
    memRdata = 32'h0;
    if (mem_req === 1'b1) begin
      if (waitCnt >= ((beatIdx == 0) ? waitCfg0 : waitCfg1)) begin
        memAck   = 1'b1;
        memRdata = wordMem.exists(mem_addr) ? wordMem[mem_addr] : 32'h0;
        ackLog.push_back('{addr: mem_addr, be: mem_be, wdata: mem_wdata, we: mem_we});
        if (mem_we) begin
          logic [31:0] w;
          w = memRdata;
          for (int i = 0; i < 4; i++) if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
          wordMem[mem_addr] = w;
        end
        waitCnt = 0;
        beatIdx++;
      end else begin
        waitCnt++;
      end
    end else begin
      waitCnt = 0;
      beatIdx = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic presetWord(input logic [31:0] addr, input logic [31:0] data);
    wordMem[addr] = data;
    for (int i = 0; i < 4; i++) refMem[addr + i] = data[8*i +: 8];
  endtask

  function automatic int refBytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  // Little-endian byte read of n bytes at any address, then extension.
  function automatic logic [31:0] refLoad(input logic [31:0] addr, input logic [1:0] size, input logic uns);
    int n;
    logic [31:0] val, a, b;
    n = refBytes(size);
    val = 32'h0;
    for (int i = 0; i < n; i++) begin
      a = addr + i;
      b = refMem.exists(a) ? 32'(refMem[a]) : 32'h0;
      val |= b << (8 * i);
    end
    if (!uns && n < 4 && val[8*n-1]) val |= ~((32'h1 << (8 * n)) - 32'h1);
    return val;
  endfunction

  task automatic refStore(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
    for (int i = 0; i < refBytes(size); i++) refMem[addr + i] = wdata[8*i +: 8];
  endtask

  // Issue one request and observe it to completion, recording latency,
  // response, beat count and any memory-output change during a wait.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int w0, input int w1);
    int g, lastSize;
    logic acked, prevReq, prevAcked;
    logic [68:0] prevOut, curOut;
    waitCfg0 = w0;
    waitCfg1 = w1;
    g = 0;
    @(negedge clk); #1;
    while (req_ready !== 1'b1 && g < 20) begin @(negedge clk); #1; g++; end
    checkOutput("ready_before_req", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    logStart = ackLog.size();
    lastSize = logStart;
    prevReq = 1'b0; prevAcked = 1'b0; prevOut = '0;
    obsUnstable = 0; obsReqCycles = 0; obsLat = 0;
    do begin
      @(negedge clk); #1;
      obsLat++;
      if (obsLat == 1) req_valid = 1'b0;
      acked = (ackLog.size() != lastSize);
      lastSize = ackLog.size();
      curOut = {mem_addr, mem_be, mem_wdata, mem_we};
      if (mem_req === 1'b1) obsReqCycles++;
      if (prevReq && !prevAcked && mem_req === 1'b1 && curOut !== prevOut) obsUnstable++;
      prevReq = (mem_req === 1'b1);
      prevAcked = acked;
      prevOut = curOut;
    end while (rsp_valid !== 1'b1 && obsLat < 80);
    obsRdata = rsp_rdata;
    obsErr   = rsp_err;
    obsBeats = ackLog.size() - logStart;
  endtask

  // Run one access and compare everything against the reference model.
  task automatic checkAgainstModel(input string tag, input logic we, input logic [1:0] size,
                                   input logic uns, input logic [31:0] addr,
                                   input logic [31:0] wdata, input int w0, input int w1);
    logic err, split;
    int expLat, expBeats;
    logic [31:0] expData;
    err   = (size == 2'b11);
    split = (int'(addr[1:0]) + refBytes(size)) > 4;
    expLat   = err ? 1 : (1 + (w0 + 1) + (split ? (w1 + 1) : 0));
    expBeats = err ? 0 : (split ? 2 : 1);
    expData  = (we || err) ? 32'h0 : refLoad(addr, size, uns);
    applyStimulus(we, size, uns, addr, wdata, w0, w1);
    checkOutput({tag, "_lat"},      32'(obsLat), 32'(expLat));
    checkOutput({tag, "_rdata"},    obsRdata, expData);
    checkOutput({tag, "_err"},      32'(obsErr), 32'(err));
    checkOutput({tag, "_beats"},    32'(obsBeats), 32'(expBeats));
    checkOutput({tag, "_unstable"}, 32'(obsUnstable), 32'h0);
    if (we && !err) refStore(addr, size, wdata);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    memAck = 1'b0; memRdata = 32'h0;
    presetWord(32'h100, 32'h44332211);
    presetWord(32'h104, 32'h88776655);
    presetWord(32'hFFFFFFFC, 32'hA1B2C3D4);
    presetWord(32'h0, 32'h0F1E2D3C);

    // Reset values.
    #2;
    checkOutput("rst_req_ready", 32'(req_ready), 32'h1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rsp_err",   32'(rsp_err),   32'h0);
    checkOutput("rst_rsp_rdata", rsp_rdata,      32'h0);
    checkOutput("rst_mem_req",   32'(mem_req),   32'h0);
    checkOutput("rst_mem_we",    32'(mem_we),    32'h0);
    checkOutput("rst_mem_addr",  mem_addr,       32'h0);
    checkOutput("rst_mem_be",    32'(mem_be),    32'h0);
    checkOutput("rst_mem_wdata", mem_wdata,      32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Split lw 0x101, zero wait.
    applyStimulus(1'b0, SZ_W, 1'b0, 32'h101, 32'h0, 0, 0);
    checkOutput("lw101_rdata", obsRdata, 32'h55443322);
    checkOutput("lw101_lat", 32'(obsLat), 32'd3);
    checkOutput("lw101_beats", 32'(obsBeats), 32'd2);
    checkOutput("lw101_addr0", ackLog[logStart].addr, 32'h100);
    checkOutput("lw101_be0", 32'(ackLog[logStart].be), 32'hF);
    checkOutput("lw101_addr1", ackLog[logStart+1].addr, 32'h104);
    checkOutput("lw101_be1", 32'(ackLog[logStart+1].be), 32'hF);
    heldRdata = obsRdata;
    @(negedge clk); #1;
    checkOutput("rsp_pulse_len", 32'(rsp_valid), 32'h0);
    checkOutput("rsp_rdata_held", rsp_rdata, heldRdata);

    // Halfword and byte loads.
    applyStimulus(1'b0, SZ_H, 1'b0, 32'h103, 32'h0, 0, 0);
    checkOutput("lh103_rdata", obsRdata, 32'h00005544);
    checkOutput("lh103_beats", 32'(obsBeats), 32'd2);
    applyStimulus(1'b0, SZ_H, 1'b0, 32'h106, 32'h0, 0, 0);
    checkOutput("lh106_rdata", obsRdata, 32'hFFFF8877);
    checkOutput("lh106_lat", 32'(obsLat), 32'd2);
    applyStimulus(1'b0, SZ_B, 1'b0, 32'h107, 32'h0, 0, 0);
    checkOutput("lb107_rdata", obsRdata, 32'hFFFFFF88);
    checkOutput("lb107_lat", 32'(obsLat), 32'd2);
    applyStimulus(1'b0, SZ_B, 1'b1, 32'h107, 32'h0, 0, 0);
    checkOutput("lbu107_rdata", obsRdata, 32'h00000088);
    checkOutput("lbu107_lat", 32'(obsLat), 32'd2);

    // Split store and readback.
    applyStimulus(1'b1, SZ_W, 1'b0, 32'h102, 32'hDEADBEEF, 0, 0);
    refStore(32'h102, SZ_W, 32'hDEADBEEF);
    checkOutput("sw102_beats", 32'(obsBeats), 32'd2);
    checkOutput("sw102_rdata", obsRdata, 32'h0);
    checkOutput("sw102_addr0", ackLog[logStart].addr, 32'h100);
    checkOutput("sw102_be0", 32'(ackLog[logStart].be), 32'hC);
    checkOutput("sw102_wd0", ackLog[logStart].wdata, 32'hBEEF0000);
    checkOutput("sw102_we0", 32'(ackLog[logStart].we), 32'h1);
    checkOutput("sw102_addr1", ackLog[logStart+1].addr, 32'h104);
    checkOutput("sw102_be1", 32'(ackLog[logStart+1].be), 32'h3);
    checkOutput("sw102_wd1", ackLog[logStart+1].wdata, 32'h0000DEAD);
    applyStimulus(1'b0, SZ_W, 1'b0, 32'h102, 32'h0, 0, 0);
    checkOutput("lw102_rdata", obsRdata, 32'hDEADBEEF);

    // Address wrap on the second beat.
    applyStimulus(1'b0, SZ_W, 1'b0, 32'hFFFFFFFE, 32'h0, 0, 0);
    checkOutput("lwwrap_addr0", ackLog[logStart].addr, 32'hFFFFFFFC);
    checkOutput("lwwrap_addr1", ackLog[logStart+1].addr, 32'h0);
    checkOutput("lwwrap_rdata", obsRdata, 32'h2D3CA1B2);

    // Illegal size.
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0, 0);
    checkOutput("illegal_err", 32'(obsErr), 32'h1);
    checkOutput("illegal_lat", 32'(obsLat), 32'd1);
    checkOutput("illegal_memreq", 32'(obsReqCycles), 32'd0);

    // Three wait states on the first beat of a split load.
    checkAgainstModel("wait3", 1'b0, SZ_W, 1'b0, 32'h101, 32'h0, 3, 0);

    // Asynchronous reset while the second beat is waiting.
    waitCfg0 = 0; waitCfg1 = 20;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_addr = 32'h101;
    @(negedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); #1;
    checkOutput("beat1_memreq", 32'(mem_req), 32'h1);
    checkOutput("beat1_addr", mem_addr, 32'h104);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_memreq", 32'(mem_req), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("arst_ready", 32'(req_ready), 32'h1);
    checkOutput("arst_state", 32'(dut.r_state), 32'(ST_IDLE));
    checkOutput("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkAgainstModel("post_rst", 1'b0, SZ_H, 1'b0, 32'h106, 32'h0, 0, 0);

    // Randomized accesses against the byte-level model.
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a  = ($urandom_range(0, 4) == 0) ? (32'hFFFFFFF8 + 32'($urandom_range(0, 7)))
                                       : (32'h100 + 32'($urandom_range(0, 31)));
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      checkAgainstModel($sformatf("rnd%0d", k), ($urandom_range(0, 9) < 3), sz,
                        1'($urandom_range(0, 1)), a, $urandom,
                        $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
